i2c_master: RTL and testbench

Single-master I2C controller that issues one-byte register writes and reads to an addressed target. It is the initiator counterpart to the team's `i2c_slave` application interface. It sits between a local command port (start, direction, target address, register address, write data) and the open-drain SCL/SDA pads on the `uio` bus. It generates START, repeated-START and STOP conditions, checks ACKs, and honours target clock stretching.

---
 rtl/i2c_master.sv | 170 +++++++++++++++++
 tb/tb_i2c_master.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master.sv
// Single-master I2C register read/write engine driving open-drain SCL/SDA enables.
// Latency 4*(DIV+1) cycles per bit slot plus stretch; start is ignored while busy.
module i2c_master #(
  parameter int DIV = 124
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] slave_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rdata,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       scl_i,
  input  logic       sda_i
);

  localparam int QW = (DIV > 0) ? $clog2(DIV + 1) : 1;
  localparam logic [QW-1:0] QMAX = QW'(DIV);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR_W, S_REG, S_DATA, S_RSTART,
    S_ADDR_R, S_READ, S_MNACK, S_ACK, S_STOP
  } state_t;

  state_t state, state_nxt, ack_src;

  logic          rw_q;
  logic [6:0]    addr_q;
  logic [7:0]    reg_q;
  logic [7:0]    wdata_q;
  logic [QW-1:0] qcnt;
  logic [1:0]    q;
  logic [2:0]    bcnt;
  logic          smp;
  logic [7:0]    rsh;
  logic [7:0]    tx_byte;
  logic          tx_bit;
  logic          hold;
  logic          tick;
  logic          slot_end;

  // The quarter counter freezes at the start of Q2 while a target stretches SCL.
  assign hold     = (state != S_IDLE) && (q == 2'd2) && (qcnt == '0) && !scl_i;
  assign tick     = (qcnt == QMAX) && !hold;
  assign slot_end = tick && (q == 2'd3);
  assign busy     = (state != S_IDLE);

  always_comb begin
    tx_byte = 8'h00;
    case (state)
      S_ADDR_W: tx_byte = {addr_q, 1'b0};
      S_REG:    tx_byte = reg_q;
      S_DATA:   tx_byte = wdata_q;
      S_ADDR_R: tx_byte = {addr_q, 1'b1};
      default:  tx_byte = 8'h00;
    endcase
    tx_bit = tx_byte[~bcnt];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    scl_oe    = 1'b0;
    sda_oe    = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_START;
      S_START: begin
        sda_oe = q[1];
        if (slot_end) state_nxt = S_ADDR_W;
      end
      S_RSTART: begin
        scl_oe = (q == 2'd0);
        sda_oe = q[1];
        if (slot_end) state_nxt = S_ADDR_R;
      end
      S_ADDR_W, S_REG, S_DATA, S_ADDR_R: begin
        scl_oe = ~q[1];
        sda_oe = ~tx_bit;
        if (slot_end && bcnt == 3'd7) state_nxt = S_ACK;
      end
      S_READ: begin
        scl_oe = ~q[1];
        if (slot_end && bcnt == 3'd7) state_nxt = S_MNACK;
      end
      S_ACK: begin
        scl_oe = ~q[1];
        if (slot_end) begin
          if (smp) state_nxt = S_STOP;
          else begin
            case (ack_src)
              S_ADDR_W: state_nxt = S_REG;
              S_REG:    state_nxt = rw_q ? S_RSTART : S_DATA;
              S_ADDR_R: state_nxt = S_READ;
              default:  state_nxt = S_STOP;
            endcase
          end
        end
      end
      S_MNACK: begin
        scl_oe = ~q[1];
        if (slot_end) state_nxt = S_STOP;
      end
      S_STOP: begin
        scl_oe = (q == 2'd0);
        sda_oe = (q != 2'd3);
        if (slot_end) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rw_q    <= 1'b0;
      addr_q  <= 7'h00;
      reg_q   <= 8'h00;
      wdata_q <= 8'h00;
      qcnt    <= '0;
      q       <= 2'd0;
      bcnt    <= 3'd0;
      smp     <= 1'b0;
      rsh     <= 8'h00;
      ack_src <= S_IDLE;
      done    <= 1'b0;
      ack_err <= 1'b0;
      rdata   <= 8'h00;
    end else begin
      done <= 1'b0;
      if (state == S_IDLE) begin
        qcnt <= '0;
        q    <= 2'd0;
        bcnt <= 3'd0;
        if (start) begin
          rw_q    <= rw;
          addr_q  <= slave_addr;
          reg_q   <= reg_addr;
          wdata_q <= wdata;
          ack_err <= 1'b0;
        end
      end else begin
        if (!hold) qcnt <= (qcnt == QMAX) ? '0 : qcnt + QW'(1);
        if (tick) q <= q + 2'd1;
        if (tick && q == 2'd2) begin
          smp <= sda_i;
          if (state == S_READ) rsh <= {rsh[6:0], sda_i};
        end
        if (state_nxt == S_ACK && state != S_ACK) ack_src <= state;
        if (slot_end) begin
          if (state inside {S_ADDR_W, S_REG, S_DATA, S_ADDR_R, S_READ}) bcnt <= bcnt + 3'd1;
          if (state == S_ACK && smp) ack_err <= 1'b1;
          if (state == S_STOP) begin
            done <= 1'b1;
            if (rw_q && !ack_err) rdata <= rsh;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_master.sv
// Randomised bench for i2c_master: open-drain bus, behavioural target at 0x70, transaction-level model.
module tb_i2c_master;

  localparam int DIV = 3;
  localparam int SLOT = 4 * (DIV + 1);
  localparam logic [6:0] SLV = 7'h70;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       rw;
  logic [6:0] slave_addr;
  logic [7:0] reg_addr;
  logic [7:0] wdata;
  logic       busy, done, ack_err;
  logic [7:0] rdata;
  logic       scl_oe, sda_oe;
  logic       scl_bus, sda_bus;

  logic       slv_low = 1'b0;
  logic       stretch_low = 1'b0;
  logic [7:0] slv_rd = 8'h00;
  int         stretch_cyc = 0;
  int         bus_log[$];

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_rdata = 8'h00;

  assign scl_bus = !(scl_oe || stretch_low);
  assign sda_bus = !(sda_oe || slv_low);

  always #5 clk = ~clk;

  i2c_master #(.DIV(DIV)) dut (
    .clk(clk), .rst(rst), .start(start), .rw(rw),
    .slave_addr(slave_addr), .reg_addr(reg_addr), .wdata(wdata),
    .busy(busy), .done(done), .ack_err(ack_err), .rdata(rdata),
    .scl_oe(scl_oe), .sda_oe(sda_oe), .scl_i(scl_bus), .sda_i(sda_bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Target model: samples the wired bus mid-cycle, logs START/bytes/ack bits/STOP.
  initial begin
    logic       p_scl, p_sda, matched, rd_mode;
    logic [7:0] shreg;
    int         bitn, byten, scnt;
    p_scl = 1'b1; p_sda = 1'b1; matched = 1'b0; rd_mode = 1'b0;
    shreg = 8'h00; bitn = 0; byten = 0; scnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        slv_low = 1'b0; stretch_low = 1'b0; matched = 1'b0; rd_mode = 1'b0;
        bitn = 0; byten = 0;
      end else begin
        if (stretch_low && !scl_oe) begin
          scnt++;
          if (scnt > stretch_cyc) stretch_low = 1'b0;
        end
        if (p_scl && scl_bus && p_sda && !sda_bus) begin
          bus_log.push_back(32'h100);
          bitn = 0; byten = 0; matched = 1'b0; rd_mode = 1'b0; slv_low = 1'b0;
        end else if (p_scl && scl_bus && !p_sda && sda_bus) begin
          bus_log.push_back(32'h200);
          bitn = 0; matched = 1'b0; slv_low = 1'b0;
        end else if (!p_scl && scl_bus) begin
          if (bitn < 8) begin
            shreg = {shreg[6:0], sda_bus};
            if (bitn == 7) begin
              bus_log.push_back(int'(shreg));
              if (byten == 0) begin
                matched = (shreg[7:1] == SLV);
                rd_mode = shreg[0];
              end
              byten++;
            end
            bitn++;
          end else begin
            bus_log.push_back(32'h300 | int'(sda_bus));
            if (rd_mode && byten >= 2 && sda_bus) matched = 1'b0;
            bitn = 0;
          end
        end else if (p_scl && !scl_bus) begin
          if (bitn == 8) begin
            slv_low = matched && !(rd_mode && byten >= 2);
            if (matched && !rd_mode && byten == 2 && stretch_cyc > 0) begin
              stretch_low = 1'b1;
              scnt = 0;
            end
          end else if (matched && rd_mode && byten >= 1) begin
            slv_low = !slv_rd[7-bitn];
          end else begin
            slv_low = 1'b0;
          end
        end
        p_scl = scl_bus;
        p_sda = sda_bus;
      end
    end
  end

  // Runs one command from a negedge; poke_at re-pulses start, rst_at aborts with reset.
  task automatic do_txn(input logic r, input logic [6:0] a, input logic [7:0] rg,
                        input logic [7:0] wd, input int stretch, input int poke_at,
                        input int rst_at);
    int  exp_q[$];
    int  exp_n, cnt, slots;
    bit  match, early_done;
    match = (a == SLV);
    exp_q = {32'h100, int'({a, 1'b0}), match ? 32'h300 : 32'h301};
    if (!match) begin
      slots = 11;
      exp_q.push_back(32'h200);
    end else if (!r) begin
      slots = 29;
      exp_q = {exp_q, int'(rg), 32'h300, int'(wd), 32'h300, 32'h200};
    end else begin
      slots = 39;
      exp_q = {exp_q, int'(rg), 32'h300, 32'h100, int'({a, 1'b1}), 32'h300,
               int'(slv_rd), 32'h301, 32'h200};
      exp_rdata = slv_rd;
    end
    exp_n = slots * SLOT + ((match && stretch > 0) ? stretch : 0);
    bus_log.delete();
    stretch_cyc = stretch;
    start = 1'b1; rw = r; slave_addr = a; reg_addr = rg; wdata = wd;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    early_done = 1'b0;
    while (busy && cnt < 3000) begin
      cnt++;
      if (cnt == 1) chk("ack_err_clear", ack_err, 0);
      if (done) early_done = 1'b1;
      if (cnt == poke_at) begin
        start = 1'b1; rw = ~r; slave_addr = a ^ 7'h2A; reg_addr = ~rg; wdata = ~wd;
      end else begin
        start = 1'b0;
      end
      if (cnt == rst_at) rst = 1'b1;
      @(negedge clk);
      if (rst_at != 0 && cnt == rst_at) begin
        chk("rst_scl_oe", scl_oe, 0);
        chk("rst_sda_oe", sda_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rdata", rdata, 0);
        rst = 1'b0;
        exp_rdata = 8'h00;
        @(negedge clk);
        return;
      end
    end
    start = 1'b0;
    chk("busy_cycles", cnt, exp_n);
    chk("done", done, 1);
    chk("end_scl_oe", scl_oe, 0);
    chk("end_sda_oe", sda_oe, 0);
    chk("ack_err", ack_err, !match);
    chk("rdata", rdata, exp_rdata);
    chk("early_done", early_done, 0);
    chk("bus_len", bus_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < bus_log.size(); i++)
      chk("bus_tok", bus_log[i], exp_q[i]);
    @(negedge clk);
    chk("done_pulse", done, 0);
  endtask

  initial begin
    logic [6:0] ra;
    rst = 1'b1; start = 1'b0; rw = 1'b0;
    slave_addr = 7'h00; reg_addr = 8'h00; wdata = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_ack_err", ack_err, 0);
    chk("reset_rdata", rdata, 0);
    chk("reset_scl_oe", scl_oe, 0);
    chk("reset_sda_oe", sda_oe, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    do_txn(1'b0, 7'h70, 8'h12, 8'hA5, 0, 0, 0);
    slv_rd = 8'h3C;
    do_txn(1'b1, 7'h70, 8'h12, 8'h00, 0, 0, 0);
    do_txn(1'b0, 7'h55, 8'h12, 8'hA5, 0, 0, 0);
    do_txn(1'b0, 7'h70, 8'h12, 8'hA5, 50, 0, 0);
    do_txn(1'b0, 7'h70, 8'h12, 8'hA5, 0, 100, 0);
    do_txn(1'b1, 7'h70, 8'h12, 8'h00, 0, 0, 200);
    do_txn(1'b0, 7'h70, 8'h34, 8'h5A, 0, 0, 0);

    for (int t = 0; t < 12; t++) begin
      if ($urandom_range(3) != 0) ra = SLV;
      else begin
        ra = 7'($urandom);
        if (ra == SLV) ra = 7'h71;
      end
      slv_rd = 8'($urandom);
      do_txn(1'($urandom), ra, 8'($urandom), 8'($urandom), 0, 0, 0);
      repeat ($urandom_range(3)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
